regfile_scoreboard: RTL and testbench

Parametrised write-port decoder and register scoreboard for the pipelined MIPS datapath. It decodes the writeback register address into a registered one-hot write-enable vector for the register file, which supersedes the fixed 5-to-32 combinational decoder. It also tracks which registers have an in-flight producer, so issue stalls on RAW/WAW hazards. The block sits between decode (issue side) and writeback (retire side).

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_scoreboard_onehot_dec.sv | 26 ++
 rtl/regfile_scoreboard.sv | 90 +++++++++
 tb/tb_regfile_scoreboard.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared defaults and helpers for the register scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DEFAULT_NREGS    = 32;
    localparam int DEFAULT_ZERO_REG = 1;

    // Count must reach NREGS itself, hence one bit beyond the address width.
    function automatic int cnt_width(input int nregs);
        return $clog2(nregs) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard_onehot_dec.sv
// ============================================================================
// Module : onehot_dec
// Brief  : Enable-gated binary-to-one-hot decoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module onehot_dec #(
    parameter int N  = 32,
    parameter int AW = $clog2(N)
) (
    input  logic          en,
    input  logic [AW-1:0] sel,
    output logic [N-1:0]  onehot
);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            assign onehot[i] = en && (sel == AW'(i));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module : regfile_scoreboard
// Brief  : Registered writeback one-hot decoder plus RAW/WAW busy scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = DEFAULT_NREGS,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = DEFAULT_ZERO_REG
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        issue_valid,
    input  logic                        issue_we,
    input  logic [AW-1:0]               issue_rs,
    input  logic [AW-1:0]               issue_rt,
    input  logic [AW-1:0]               issue_rd,
    output logic                        issue_stall,
    output logic                        issue_fire,
    input  logic                        wb_en,
    input  logic [AW-1:0]               wb_addr,
    output logic [NREGS-1:0]            wen_onehot,
    output logic [NREGS-1:0]            busy,
    output logic [cnt_width(NREGS)-1:0] pend_cnt
);

    localparam int CW = cnt_width(NREGS);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [NREGS-1:0] wen_q;
    logic [CW-1:0]    pend_q, pend_d;
    logic [NREGS-1:0] w_busy_eff;
    logic [NREGS-1:0] w_set_vec, w_clr_vec;
    logic             w_set_en, w_clr_en;

    // Hazard check sees an empty scoreboard while reset is held.
    assign w_busy_eff  = reset ? '0 : busy_q;
    assign issue_stall = issue_valid &&
                         (w_busy_eff[issue_rs] || w_busy_eff[issue_rt] ||
                          (issue_we && w_busy_eff[issue_rd]));
    assign issue_fire  = issue_valid && !issue_stall;

    assign w_set_en = issue_fire && issue_we &&
                      !((ZERO_REG != 0) && (issue_rd == '0));
    assign w_clr_en = wb_en && !((ZERO_REG != 0) && (wb_addr == '0));

    onehot_dec #(.N(NREGS), .AW(AW)) u_set_dec (
        .en     (w_set_en),
        .sel    (issue_rd),
        .onehot (w_set_vec)
    );

    onehot_dec #(.N(NREGS), .AW(AW)) u_clr_dec (
        .en     (w_clr_en),
        .sel    (wb_addr),
        .onehot (w_clr_vec)
    );

    // Set is applied after clear so a same-register collision stays busy.
    always_comb begin
        busy_d = (busy_q & ~w_clr_vec) | w_set_vec;
        pend_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            pend_d = pend_d + CW'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            wen_q  <= '0;
            pend_q <= '0;
        end else begin
            busy_q <= busy_d;
            wen_q  <= w_clr_vec;
            pend_q <= pend_d;
        end
    end

    assign busy       = busy_q;
    assign wen_onehot = wen_q;
    assign pend_cnt   = pend_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// Module : tb_regfile_scoreboard
// Brief  : Directed plus random bench for regfile_scoreboard against a model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: 32 regs, ZERO_REG=1
    logic        reset, iv, iwe, wb_en;
    logic [4:0]  rs, rt, rd, wb_addr;
    logic        stall, fire;
    logic [31:0] wen, busy;
    logic [5:0]  pend;

    // Instance B: 32 regs, ZERO_REG=0
    logic        b_iv, b_iwe, b_wb_en;
    logic [4:0]  b_rs, b_rt, b_rd, b_wb_addr;
    logic        b_stall, b_fire;
    logic [31:0] b_wen, b_busy;
    logic [5:0]  b_pend;

    // Instance C: 8 regs, ZERO_REG=1
    logic        c_iv, c_iwe, c_wb_en;
    logic [2:0]  c_rs, c_rt, c_rd, c_wb_addr;
    logic        c_stall, c_fire;
    logic [7:0]  c_wen, c_busy;
    logic [3:0]  c_pend;

    regfile_scoreboard #(.NREGS(32), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset(reset), .issue_valid(iv), .issue_we(iwe),
        .issue_rs(rs), .issue_rt(rt), .issue_rd(rd),
        .issue_stall(stall), .issue_fire(fire),
        .wb_en(wb_en), .wb_addr(wb_addr),
        .wen_onehot(wen), .busy(busy), .pend_cnt(pend));

    regfile_scoreboard #(.NREGS(32), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .issue_valid(b_iv), .issue_we(b_iwe),
        .issue_rs(b_rs), .issue_rt(b_rt), .issue_rd(b_rd),
        .issue_stall(b_stall), .issue_fire(b_fire),
        .wb_en(b_wb_en), .wb_addr(b_wb_addr),
        .wen_onehot(b_wen), .busy(b_busy), .pend_cnt(b_pend));

    regfile_scoreboard #(.NREGS(8), .ZERO_REG(1)) dut_c (
        .clk(clk), .reset(reset), .issue_valid(c_iv), .issue_we(c_iwe),
        .issue_rs(c_rs), .issue_rt(c_rt), .issue_rd(c_rd),
        .issue_stall(c_stall), .issue_fire(c_fire),
        .wb_en(c_wb_en), .wb_addr(c_wb_addr),
        .wen_onehot(c_wen), .busy(c_busy), .pend_cnt(c_pend));

    // Reference model of instance A: set of in-flight register numbers.
    bit          m_busy [32];
    logic [31:0] m_wen;

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) v = v | (32'd1 << i);
        return v;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of instance A: combinational check mid-cycle, registered after the edge.
    task automatic cycle_a(input string tag);
        bit exp_stall, exp_fire;
        bit nxt [32];
        logic [31:0] nxt_wen;
        @(negedge clk);
        exp_stall = iv && !reset &&
                    (m_busy[rs] || m_busy[rt] || (iwe && m_busy[rd]));
        exp_fire  = iv && !exp_stall;
        chk({tag, "_stall"}, 64'(stall), 64'(exp_stall));
        chk({tag, "_fire"},  64'(fire),  64'(exp_fire));
        nxt = m_busy;
        nxt_wen = '0;
        if (reset) begin
            foreach (nxt[i]) nxt[i] = 1'b0;
        end else begin
            if (wb_en && wb_addr != 0) begin
                nxt[wb_addr] = 1'b0;
                nxt_wen = 32'd1 << wb_addr;
            end
            if (exp_fire && iwe && rd != 0) nxt[rd] = 1'b1;
        end
        @(posedge clk);
        #1;
        m_busy = nxt;
        m_wen  = nxt_wen;
        chk({tag, "_busy"}, 64'(busy), 64'(model_busy_vec()));
        chk({tag, "_wen"},  64'(wen),  64'(m_wen));
        chk({tag, "_pend"}, 64'(pend), 64'(model_count()));
    endtask

    task automatic drive_a(input bit v, input bit we, input int s, input int t,
                           input int d, input bit w, input int wa);
        iv = v; iwe = we; rs = 5'(s); rt = 5'(t); rd = 5'(d);
        wb_en = w; wb_addr = 5'(wa);
    endtask

    initial begin
        reset = 1'b1;
        drive_a(0, 0, 0, 0, 0, 0, 0);
        {b_iv, b_iwe, b_wb_en, b_rs, b_rt, b_rd, b_wb_addr} = '0;
        {c_iv, c_iwe, c_wb_en, c_rs, c_rt, c_rd, c_wb_addr} = '0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        #1;
        cycle_a("reset0");
        cycle_a("reset1");
        reset = 1'b0;

        // Writeback to idle register: one-cycle pulse, no busy change.
        drive_a(0, 0, 0, 0, 0, 1, 5);
        cycle_a("wb5");
        chk("wb5_onehot", 64'(wen), 64'h20);
        drive_a(0, 0, 0, 0, 0, 0, 0);
        cycle_a("wb5_gone");
        chk("wb5_pulse_end", 64'(wen), 64'h0);

        // RAW hazard on r7, released by writeback one cycle later.
        drive_a(1, 1, 0, 0, 7, 0, 0);
        cycle_a("iss7");
        drive_a(1, 0, 7, 0, 0, 0, 0);
        #1;
        chk("raw7_stall", 64'(stall), 64'h1);
        cycle_a("raw7_hold");
        drive_a(1, 0, 7, 0, 0, 1, 7);
        cycle_a("raw7_wb");
        drive_a(1, 0, 7, 0, 0, 0, 0);
        #1;
        chk("raw7_fire", 64'(fire), 64'h1);
        cycle_a("raw7_go");

        // Same-cycle set and clear of r9.
        drive_a(1, 1, 0, 0, 9, 1, 9);
        cycle_a("setclr9");
        chk("setclr9_busy9", 64'(busy[9]), 64'h1);
        chk("setclr9_pend", 64'(pend), 64'h1);

        // Register 0 is never tracked with ZERO_REG=1.
        drive_a(1, 1, 0, 0, 0, 1, 0);
        cycle_a("zero");
        chk("zero_wen", 64'(wen), 64'h0);
        drive_a(1, 0, 0, 0, 0, 0, 0);
        cycle_a("zero_rs");

        // Fill registers 1..31, then reset for a single cycle.
        reset = 1'b1;
        drive_a(0, 0, 0, 0, 0, 0, 0);
        cycle_a("clr");
        reset = 1'b0;
        for (int r = 1; r < 32; r++) begin
            drive_a(1, 1, 0, 0, r, 0, 0);
            cycle_a("fill");
        end
        chk("fill_pend", 64'(pend), 64'd31);
        chk("fill_busy", 64'(busy), 64'hFFFF_FFFE);
        reset = 1'b1;
        drive_a(0, 0, 0, 0, 0, 1, 3);
        cycle_a("fill_rst");
        chk("fill_rst_busy", 64'(busy), 64'h0);
        reset = 1'b0;

        // Random traffic, occasional mid-stream reset.
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            drive_a($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11),
                    $urandom_range(0, 2) == 0, $urandom_range(0, 11));
            cycle_a("rnd");
        end
        reset = 1'b0;
        drive_a(0, 0, 0, 0, 0, 0, 0);

        // Instance B: register 0 is an ordinary register.
        b_iv = 1; b_iwe = 1; b_rd = 5'd0; b_wb_en = 1; b_wb_addr = 5'd0;
        @(negedge clk);
        chk("b_zero_fire", 64'(b_fire), 64'h1);
        @(posedge clk); #1;
        chk("b_zero_busy", 64'(b_busy), 64'h1);
        chk("b_zero_wen", 64'(b_wen), 64'h1);
        b_iwe = 0; b_wb_en = 0; b_rs = 5'd0;
        @(negedge clk);
        chk("b_zero_stall", 64'(b_stall), 64'h1);
        b_iv = 0;

        // Instance C: 8-register build.
        c_wb_en = 1; c_wb_addr = 3'd7;
        @(posedge clk); #1;
        chk("c_wen7", 64'(c_wen), 64'h80);
        c_wb_en = 0; c_iv = 1; c_iwe = 1; c_rd = 3'd2;
        @(posedge clk); #1;
        chk("c_pend1", 64'(c_pend), 64'h1);
        chk("c_busy2", 64'(c_busy), 64'h04);
        c_iwe = 0; c_rs = 3'd2;
        @(negedge clk);
        chk("c_stall2", 64'(c_stall), 64'h1);
        c_iv = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
